// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port among NUM_REQ cache requesters, one transaction
// at a time, with fixed-priority or round-robin selection of the next requester.
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter bit RR_MODE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [LINE_W-1:0]         rdata,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_W-1:0]         mem_wdata,
    input  logic [LINE_W-1:0]         mem_rdata,
    input  logic                      mem_ready
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_grant, r_rr_ptr, w_winner;
    logic                r_is_wr, w_wr_sel;
    logic [ADDR_W-1:0]   r_mem_addr, w_addr_sel;
    logic [LINE_W-1:0]   r_mem_wdata, r_rdata, w_wdata_sel;
    logic [NUM_REQ-1:0]  w_pending, w_ready;
    logic [IDX_W:0]      w_sum;

    assign w_pending = req_rd | req_wr;

    // Round-robin scans from the slot after the last served requester; the
    // descending loop lets the nearest pending slot overwrite farther ones.
    always_comb begin
        w_winner = '0;
        w_sum    = '0;
        if (RR_MODE == 1'b0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_pending[i]) w_winner = IDX_W'(i);
            end
        end else begin
            for (int off = NUM_REQ; off >= 1; off--) begin
                w_sum = {1'b0, r_rr_ptr} + (IDX_W + 1)'(off);
                if (w_sum >= (IDX_W + 1)'(NUM_REQ)) w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
                if (w_pending[w_sum[IDX_W-1:0]]) w_winner = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_wr_sel    = 1'b0;
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_wr_sel    = req_wr[i];
                w_addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
                w_wdata_sel = req_wdata[i*LINE_W +: LINE_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_pending) w_next = ISSUE;
            ISSUE:   if (mem_ready) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ready = '0;
        if (r_state == RESP) w_ready[r_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_is_wr     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (|w_pending) begin
                        r_grant     <= w_winner;
                        r_is_wr     <= w_wr_sel;
                        r_mem_addr  <= w_addr_sel;
                        r_mem_wdata <= w_wdata_sel;
                    end
                end
                ISSUE: begin
                    if (mem_ready && !r_is_wr) r_rdata <= mem_rdata;
                end
                RESP: begin
                    r_rr_ptr <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign req_busy  = w_pending & ~w_ready;
    assign mem_rd    = (r_state == ISSUE) && !r_is_wr;
    assign mem_wr    = (r_state == ISSUE) && r_is_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

endmodule
